logic_axi4_stream_packet_arbiter: RTL and testbench

- Packet-aware round-robin arbiter that merges INPUTS AXI4-Stream sources into one AXI4-Stream sink.
- Sits in front of the AXI4-Stream packet buffer so several producers share one buffer.
- A grant is held from the first beat of a packet until the beat with tlast is accepted, so packets are never interleaved at the output.

---
 rtl/logic_axi4_stream_packet_arbiter_if.sv | 29 ++
 rtl/logic_axi4_stream_packet_arbiter.sv | 119 +++++++++++
 tb/tb_logic_axi4_stream_packet_arbiter.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/logic_axi4_stream_packet_arbiter_if.sv
// AXI4-Stream bundle used on both sides of the packet arbiter; LANES > 1 packs
// several streams side by side, lane i occupying slice i of every field.
interface logic_axi4_stream_packet_arbiter_if #(
  parameter int unsigned LANES       = 1,
  parameter int unsigned TDATA_BYTES = 4,
  parameter int unsigned TDEST_WIDTH = 1,
  parameter int unsigned TUSER_WIDTH = 1,
  parameter int unsigned TID_WIDTH   = 2
);
  logic [LANES-1:0]               tvalid;
  logic [LANES-1:0]               tlast;
  logic [LANES*TDATA_BYTES*8-1:0] tdata;
  logic [LANES*TDATA_BYTES-1:0]   tkeep;
  logic [LANES*TDATA_BYTES-1:0]   tstrb;
  logic [LANES*TDEST_WIDTH-1:0]   tdest;
  logic [LANES*TUSER_WIDTH-1:0]   tuser;
  logic [LANES*TID_WIDTH-1:0]     tid;
  logic [LANES-1:0]               tready;

  modport master (
    output tvalid, tlast, tdata, tkeep, tstrb, tdest, tuser, tid,
    input  tready
  );

  modport slave (
    input  tvalid, tlast, tdata, tkeep, tstrb, tdest, tuser, tid,
    output tready
  );
endinterface

// File: rtl/logic_axi4_stream_packet_arbiter.sv
// Packet-aware round-robin arbiter merging INPUTS AXI4-Stream sources into one sink.
// Define LOGIC_AXI4_STREAM_PACKET_ARBITER_TID_TAG_EN to replace tx tid with the grant index.
module logic_axi4_stream_packet_arbiter #(
  parameter int unsigned INPUTS      = 4,
  parameter int unsigned TDATA_BYTES = 4,
  parameter int unsigned TDEST_WIDTH = 1,
  parameter int unsigned TUSER_WIDTH = 1,
  parameter int unsigned TID_WIDTH   = 2,
  parameter bit          USE_TLAST   = 1'b1
) (
  input  logic                        aclk,
  input  logic                        areset,
  logic_axi4_stream_packet_arbiter_if.slave  rx,
  logic_axi4_stream_packet_arbiter_if.master tx,
  output logic                        grant_active_o,
  output logic [$clog2(INPUTS)-1:0]   grant_index_o
);

  localparam int unsigned IdxW  = $clog2(INPUTS);
  localparam int unsigned DataW = TDATA_BYTES * 8;

  if (INPUTS < 2) begin : g_inputs_check
    $error("INPUTS must be at least 2");
  end

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   grant_q, grant_d;
  logic [IdxW-1:0]   next_idx;
  logic [IdxW-1:0]   cand;
  logic              found;
  logic              locked;
  logic              xfer_last;

  assign locked    = (state_q == StLocked);
  assign xfer_last = locked & tx.tvalid[0] & tx.tready[0] & tx.tlast[0];

  // Round-robin search starting just after the last granted input.
  always_comb begin
    next_idx = grant_q;
    found    = 1'b0;
    cand     = grant_q;
    for (int k = 1; k <= int'(INPUTS); k++) begin
      cand = IdxW'((int'(grant_q) + k) % int'(INPUTS));
      if (!found && rx.tvalid[cand]) begin
        found    = 1'b1;
        next_idx = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          grant_d = next_idx;
          state_d = StLocked;
        end
      end
      StLocked: begin
        if (xfer_last) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= StIdle;
      grant_q <= IdxW'(INPUTS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  // Combinational pass-through of the granted lane; everything is zero outside LOCKED.
  always_comb begin
    rx.tready = '0;
    tx.tvalid = '0;
    tx.tlast  = '0;
    tx.tdata  = '0;
    tx.tkeep  = '0;
    tx.tstrb  = '0;
    tx.tdest  = '0;
    tx.tuser  = '0;
    tx.tid    = '0;
    if (locked) begin
      tx.tvalid[0] = rx.tvalid[grant_q];
      tx.tlast[0]  = USE_TLAST ? rx.tlast[grant_q] : 1'b1;
      tx.tdata     = rx.tdata[grant_q*DataW +: DataW];
      tx.tkeep     = rx.tkeep[grant_q*TDATA_BYTES +: TDATA_BYTES];
      tx.tstrb     = rx.tstrb[grant_q*TDATA_BYTES +: TDATA_BYTES];
      tx.tdest     = rx.tdest[grant_q*TDEST_WIDTH +: TDEST_WIDTH];
      tx.tuser     = rx.tuser[grant_q*TUSER_WIDTH +: TUSER_WIDTH];
`ifdef LOGIC_AXI4_STREAM_PACKET_ARBITER_TID_TAG_EN
      tx.tid       = TID_WIDTH'(grant_q);
`else
      tx.tid       = rx.tid[grant_q*TID_WIDTH +: TID_WIDTH];
`endif
      rx.tready[grant_q] = tx.tready[0];
    end
  end

`ifdef LOGIC_AXI4_STREAM_PACKET_ARBITER_TID_TAG_EN
  if (TID_WIDTH < $clog2(INPUTS)) begin : g_tid_width_check
    $error("TID_WIDTH too narrow to carry the grant index");
  end
  logic unused_rx_tid;
  assign unused_rx_tid = ^rx.tid;
`endif

  assign grant_active_o = locked;
  assign grant_index_o  = grant_q;

endmodule

// File: tb/tb_logic_axi4_stream_packet_arbiter.sv
// Directed self-checking bench for logic_axi4_stream_packet_arbiter (4 inputs, 32-bit data).
module tb_logic_axi4_stream_packet_arbiter;

  logic       aclk;
  logic       areset;
  logic       grant_active;
  logic [1:0] grant_index;

  logic_axi4_stream_packet_arbiter_if #(
    .LANES(4), .TDATA_BYTES(4), .TDEST_WIDTH(1), .TUSER_WIDTH(1), .TID_WIDTH(2)
  ) rx_bus ();
  logic_axi4_stream_packet_arbiter_if #(
    .LANES(1), .TDATA_BYTES(4), .TDEST_WIDTH(1), .TUSER_WIDTH(1), .TID_WIDTH(2)
  ) tx_bus ();

  logic_axi4_stream_packet_arbiter #(
    .INPUTS(4), .TDATA_BYTES(4), .TDEST_WIDTH(1), .TUSER_WIDTH(1), .TID_WIDTH(2),
    .USE_TLAST(1'b1)
  ) dut (
    .aclk           (aclk),
    .areset         (areset),
    .rx             (rx_bus.slave),
    .tx             (tx_bus.master),
    .grant_active_o (grant_active),
    .grant_index_o  (grant_index)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Source model state per input
  int         src_cnt[4];
  int         src_len[4];
  int         src_beat[4];
  logic [7:0] src_base[4];
  logic [1:0] src_tid[4];

  logic [7:0] out_data[$];
  logic [1:0] out_src[$];
  int         out_cyc[$];

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      rx_bus.tvalid[i]         = (src_cnt[i] > 0);
      rx_bus.tlast[i]          = (src_beat[i] == src_len[i] - 1);
      rx_bus.tdata[i*32 +: 32] = {24'h0, src_base[i] + 8'(src_beat[i])};
      rx_bus.tkeep[i*4 +: 4]   = 4'hF;
      rx_bus.tstrb[i*4 +: 4]   = 4'hF;
      rx_bus.tdest[i]          = 1'(i);
      rx_bus.tuser[i]          = 1'b1;
      rx_bus.tid[i*2 +: 2]     = src_tid[i];
    end
  endtask

  task automatic set_src(input int i, input int cnt, input int len, input logic [7:0] base);
    src_cnt[i]  = cnt;
    src_len[i]  = len;
    src_beat[i] = 0;
    src_base[i] = base;
    src_tid[i]  = 2'(i);
  endtask

  // One clock: record handshakes, advance sources after the edge, settle at the next negedge.
  task automatic cycle();
    logic [3:0] hs;
    #1;
    hs = rx_bus.tvalid & rx_bus.tready;
    if (tx_bus.tvalid[0] && tx_bus.tready[0]) begin
      out_data.push_back(tx_bus.tdata[7:0]);
      out_src.push_back(grant_index);
      out_cyc.push_back(cyc);
    end
    @(posedge aclk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (hs[i]) begin
        src_beat[i]++;
        if (src_beat[i] == src_len[i]) begin
          src_beat[i] = 0;
          src_cnt[i]--;
          src_base[i] = src_base[i] + 8'(src_len[i]);
        end
      end
    end
    drive();
    cyc++;
    @(negedge aclk);
    #1;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    for (int i = 0; i < 4; i++) set_src(i, 0, 1, 8'h00);
    tx_bus.tready = 1'b1;
    drive();
    @(negedge aclk);
    @(negedge aclk);
    areset = 1'b0;
    out_data.delete();
    out_src.delete();
    out_cyc.delete();
    cyc = 0;
  endtask

  task automatic test_reset();
    areset        = 1'b1;
    tx_bus.tready = 1'b1;
    for (int i = 0; i < 4; i++) set_src(i, 1, 1, 8'hA0 + 8'(i));
    drive();
    @(negedge aclk);
    #1;
    checks++; if (rx_bus.tready !== 4'b0000) begin failures++;
      $display("FAIL reset_rx_tready got=%b exp=0000", rx_bus.tready); end
    checks++; if (tx_bus.tvalid[0] !== 1'b0) begin failures++;
      $display("FAIL reset_tx_tvalid got=%b exp=0", tx_bus.tvalid[0]); end
    checks++; if (tx_bus.tdata !== 32'h0 || tx_bus.tkeep !== 4'h0 || tx_bus.tid !== 2'h0) begin
      failures++;
      $display("FAIL reset_tx_zero data=%h keep=%h tid=%h exp=0", tx_bus.tdata, tx_bus.tkeep,
               tx_bus.tid); end
    checks++; if (grant_active !== 1'b0) begin failures++;
      $display("FAIL reset_grant_active got=%b exp=0", grant_active); end
    checks++; if (grant_index !== 2'd3) begin failures++;
      $display("FAIL reset_grant_index got=%0d exp=3", grant_index); end
    areset = 1'b0;
    cyc    = 0;
    #1;
    checks++; if (tx_bus.tvalid[0] !== 1'b0) begin failures++;
      $display("FAIL release_bubble_tvalid got=%b exp=0", tx_bus.tvalid[0]); end
    cycle();
    checks++; if (grant_active !== 1'b1 || grant_index !== 2'd0) begin failures++;
      $display("FAIL first_grant active=%b idx=%0d exp=1/0", grant_active, grant_index); end
    checks++; if (tx_bus.tvalid[0] !== 1'b1 || tx_bus.tdata[7:0] !== 8'hA0) begin failures++;
      $display("FAIL first_beat valid=%b data=%h exp=1/a0", tx_bus.tvalid[0], tx_bus.tdata[7:0]);
    end
    checks++; if (rx_bus.tready !== 4'b0001) begin failures++;
      $display("FAIL first_rx_tready got=%b exp=0001", rx_bus.tready); end
  endtask

  task automatic test_locking();
    logic [7:0] exp_d[5] = '{8'h11, 8'h12, 8'h13, 8'h21, 8'h22};
    logic [1:0] exp_s[5] = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2};
    int         exp_c[5] = '{1, 2, 3, 5, 6};
    do_reset();
    set_src(1, 1, 3, 8'h11);
    drive();
    cycle();
    cycle();
    set_src(2, 1, 2, 8'h21);
    drive();
    #1;
    checks++; if (rx_bus.tvalid[2] !== 1'b1 || rx_bus.tready[2] !== 1'b0) begin failures++;
      $display("FAIL lock_other_tready got=%b exp=0", rx_bus.tready[2]); end
    checks++; if (grant_index !== 2'd1 || tx_bus.tid !== 2'd1) begin failures++;
      $display("FAIL lock_grant idx=%0d tid=%0d exp=1/1", grant_index, tx_bus.tid); end
    for (int n = 0; n < 6; n++) cycle();
    checks++; if (out_data.size() != 5) begin failures++;
      $display("FAIL lock_beat_count got=%0d exp=5", out_data.size()); end
    else begin
      for (int n = 0; n < 5; n++) begin
        checks++;
        if (out_data[n] !== exp_d[n] || out_src[n] !== exp_s[n] || out_cyc[n] != exp_c[n]) begin
          failures++;
          $display("FAIL lock_beat%0d data=%h src=%0d cyc=%0d exp=%h/%0d/%0d", n, out_data[n],
                   out_src[n], out_cyc[n], exp_d[n], exp_s[n], exp_c[n]);
        end
      end
    end
  endtask

  task automatic test_fairness();
    int cnt[4] = '{0, 0, 0, 0};
    do_reset();
    for (int i = 0; i < 4; i++) set_src(i, 2, 2, 8'h80 + 8'(16 * i));
    drive();
    for (int n = 0; n < 26; n++) cycle();
    checks++; if (out_data.size() != 16) begin failures++;
      $display("FAIL fair_beat_count got=%0d exp=16", out_data.size()); end
    else begin
      for (int p = 0; p < 8; p++) begin
        checks++;
        if (out_src[2*p] !== 2'(p % 4) || out_src[2*p+1] !== 2'(p % 4) ||
            out_data[2*p] !== 8'h80 + 8'(16 * (p % 4) + 2 * (p / 4))) begin
          failures++;
          $display("FAIL fair_pkt%0d src=%0d data=%h exp=%0d/%h", p, out_src[2*p], out_data[2*p],
                   p % 4, 8'h80 + 8'(16 * (p % 4) + 2 * (p / 4)));
        end
      end
      foreach (out_src[n]) cnt[out_src[n]]++;
      for (int i = 0; i < 4; i++) begin
        checks++; if (cnt[i] != 4) begin failures++;
          $display("FAIL fair_count_in%0d got=%0d exp=4", i, cnt[i]); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] exp_tid;
`ifdef LOGIC_AXI4_STREAM_PACKET_ARBITER_TID_TAG_EN
    exp_tid = 2'd3;
`else
    exp_tid = 2'd0;
`endif
    do_reset();
    set_src(3, 1, 3, 8'h31);
    src_tid[3] = 2'd0;
    drive();
    cycle();
    checks++; if (grant_index !== 2'd3 || tx_bus.tdata[7:0] !== 8'h31) begin failures++;
      $display("FAIL bp_grant idx=%0d data=%h exp=3/31", grant_index, tx_bus.tdata[7:0]); end
    cycle();
    for (int n = 0; n < 2; n++) begin
      tx_bus.tready = 1'b0;
      #1;
      checks++;
      if (tx_bus.tvalid[0] !== 1'b1 || tx_bus.tdata[7:0] !== 8'h32 || rx_bus.tready[3] !== 1'b0)
      begin
        failures++;
        $display("FAIL bp_stall%0d valid=%b data=%h rdy3=%b exp=1/32/0", n, tx_bus.tvalid[0],
                 tx_bus.tdata[7:0], rx_bus.tready[3]);
      end
      checks++; if (tx_bus.tid !== exp_tid) begin failures++;
        $display("FAIL bp_tid got=%0d exp=%0d", tx_bus.tid, exp_tid); end
      cycle();
    end
    tx_bus.tready = 1'b1;
    #1;
    checks++; if (rx_bus.tready[3] !== 1'b1 || tx_bus.tdata[7:0] !== 8'h32) begin failures++;
      $display("FAIL bp_resume rdy3=%b data=%h exp=1/32", rx_bus.tready[3], tx_bus.tdata[7:0]);
    end
    for (int n = 0; n < 4; n++) cycle();
    checks++;
    if (out_data.size() != 3 || out_data[0] !== 8'h31 || out_data[1] !== 8'h32 ||
        out_data[2] !== 8'h33) begin
      failures++;
      $display("FAIL bp_stream count=%0d exp=3 beats 31,32,33", out_data.size());
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_src(2, 1, 4, 8'h51);
    drive();
    cycle();
    cycle();
    cycle();
    checks++; if (tx_bus.tdata[7:0] !== 8'h53 || grant_index !== 2'd2) begin failures++;
      $display("FAIL mid_pre data=%h idx=%0d exp=53/2", tx_bus.tdata[7:0], grant_index); end
    areset = 1'b1;
    #1;
    checks++;
    if (tx_bus.tvalid[0] !== 1'b0 || tx_bus.tdata !== 32'h0 || rx_bus.tready !== 4'b0000) begin
      failures++;
      $display("FAIL mid_async valid=%b data=%h rdy=%b exp=0/0/0", tx_bus.tvalid[0],
               tx_bus.tdata, rx_bus.tready);
    end
    checks++; if (grant_active !== 1'b0 || grant_index !== 2'd3) begin failures++;
      $display("FAIL mid_state active=%b idx=%0d exp=0/3", grant_active, grant_index); end
    set_src(0, 1, 1, 8'h61);
    set_src(2, 1, 4, 8'h51);
    drive();
    #1;
    areset = 1'b0;
    cycle();
    checks++; if (grant_index !== 2'd0 || tx_bus.tdata[7:0] !== 8'h61) begin failures++;
      $display("FAIL mid_regrant idx=%0d data=%h exp=0/61", grant_index, tx_bus.tdata[7:0]); end
  endtask

  initial begin
    test_reset();
    test_locking();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
